// File: rtl/wave_pkg.sv
// Shared wave-distortion math and frame typedefs for the wave writer and reader.
// wave_offset() gives the combined offset; the reader pipelines the same helper functions.
package wave_pkg;

  localparam int WIDTH  = 240;
  localparam int HEIGHT = 320;

  typedef logic [6:0]         pixel_t;
  typedef logic [10:0]        hcount_t;
  typedef logic [9:0]         vcount_t;
  typedef logic signed [9:0]  hterm_t;
  typedef logic signed [15:0] offset_t;

  function automatic hterm_t wave_top(input hterm_t h);
    return (h - 10'sd240) >>> 3;
  endfunction

  function automatic hterm_t wave_mid(input hterm_t h);
    return (h - 10'sd120) >>> 4;
  endfunction

  function automatic hterm_t wave_bot(input hterm_t h);
    return (-h) >>> 3;
  endfunction

  function automatic offset_t wave_product(input hterm_t a, input hterm_t b);
    return offset_t'(a) * offset_t'(b);
  endfunction

  function automatic offset_t wave_offset(input hcount_t hc, input logic en);
    hterm_t h;
    h = $signed({1'b0, hc[8:0]});
    if (!en) return '0;
    return (hc > 11'd120) ? wave_product(wave_mid(h), wave_top(h))
                          : wave_product(wave_mid(h), wave_bot(h));
  endfunction

endpackage

// File: rtl/wave_unwarp_reader_if.sv
// Video coordinate / BRAM read / pixel return bundle for the unwarp reader.
interface wave_unwarp_reader_if #(
  parameter int ADDR_W = 17
);
  import wave_pkg::*;

  hcount_t           hcount_in;
  vcount_t           vcount_in;
  logic              data_valid_in;
  logic              wave_en_in;
  logic [ADDR_W-1:0] addr_out;
  pixel_t            rdata_in;
  hcount_t           hcount_out;
  vcount_t           vcount_out;
  logic              data_valid_out;
  pixel_t            pixel_out;

  modport master (
    output hcount_in, vcount_in, data_valid_in, wave_en_in, rdata_in,
    input  addr_out, hcount_out, vcount_out, data_valid_out, pixel_out
  );

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, wave_en_in, rdata_in,
    output addr_out, hcount_out, vcount_out, data_valid_out, pixel_out
  );
endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/wave_unwarp_reader.sv
// Inverse wave row offset, BRAM read address generation and pixel return with
// the timing sideband re-aligned to the returned pixel.
module wave_unwarp_reader
  import wave_pkg::*;
#(
  parameter int WIDTH    = wave_pkg::WIDTH,
  parameter int HEIGHT   = wave_pkg::HEIGHT,
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 17
) (
  input  logic               clk_in,
  input  logic               rst_in,
  wave_unwarp_reader_if.slave bus
);

  localparam int LAT  = 4 + READ_LAT;
  localparam int SB_W = 2 + $bits(hcount_t) + $bits(vcount_t);

  // Single wrap is enough: the offset never exceeds one frame height.
  function automatic logic signed [11:0] wrap_row(input logic signed [11:0] s);
    if (s < 0) return s + $signed(12'(HEIGHT));
    else if (s >= $signed(12'(HEIGHT))) return s - $signed(12'(HEIGHT));
    return s;
  endfunction

  hterm_t             h_s0;
  logic               in_range_s0;
  logic               vld_p1, en_p1, gt_p1;
  logic [8:0]         h_p1;
  vcount_t            v_p1;
  hterm_t             top_p1, mid_p1, bot_p1;
  logic               vld_p2;
  logic [8:0]         h_p2;
  vcount_t            v_p2;
  offset_t            off_p2;
  logic               vld_p3;
  logic [8:0]         h_p3;
  logic signed [11:0] row_p3;
  logic [ADDR_W-1:0]  addr_p3;

  assign h_s0        = $signed({1'b0, bus.hcount_in[8:0]});
  assign in_range_s0 = (bus.hcount_in < 11'(WIDTH)) && (bus.vcount_in < 10'(HEIGHT));

  // S1: wave terms from the raw column
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p1 <= 1'b0;
      en_p1  <= 1'b0;
      gt_p1  <= 1'b0;
      h_p1   <= '0;
      v_p1   <= '0;
      top_p1 <= '0;
      mid_p1 <= '0;
      bot_p1 <= '0;
    end else begin
      vld_p1 <= bus.data_valid_in;
      en_p1  <= bus.wave_en_in;
      gt_p1  <= bus.hcount_in > 11'd120;
      h_p1   <= bus.hcount_in[8:0];
      v_p1   <= bus.vcount_in;
      top_p1 <= wave_top(h_s0);
      mid_p1 <= wave_mid(h_s0);
      bot_p1 <= wave_bot(h_s0);
    end
  end

  // S2: row offset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p2 <= 1'b0;
      h_p2   <= '0;
      v_p2   <= '0;
      off_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      h_p2   <= h_p1;
      v_p2   <= v_p1;
      if (!en_p1)     off_p2 <= '0;
      else if (gt_p1) off_p2 <= wave_product(mid_p1, top_p1);
      else            off_p2 <= wave_product(mid_p1, bot_p1);
    end
  end

  // S3: inverse offset and wrap into the frame
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p3 <= 1'b0;
      h_p3   <= '0;
      row_p3 <= '0;
    end else begin
      vld_p3 <= vld_p2;
      h_p3   <= h_p2;
      row_p3 <= wrap_row($signed(12'($signed({6'b0, v_p2}) - off_p2)));
    end
  end

  assign addr_p3 = ADDR_W'($unsigned(row_p3)) * ADDR_W'(WIDTH) + ADDR_W'(h_p3);

  // S4: BRAM address, held across invalid slots
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     bus.addr_out <= '0;
    else if (vld_p3) bus.addr_out <= addr_p3;
  end

  logic [SB_W-1:0] sb_d, sb_q;
  logic            sb_vld, sb_rng;
  hcount_t         sb_h;
  vcount_t         sb_v;

  assign sb_d = {bus.data_valid_in, in_range_s0, bus.hcount_in, bus.vcount_in};
  assign {sb_vld, sb_rng, sb_h, sb_v} = sb_q;

  pipe_delay #(
    .W     (SB_W),
    .DEPTH (LAT)
  ) u_sideband (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (sb_d),
    .q      (sb_q)
  );

  // Output: pixel joined with its delayed sideband
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.data_valid_out <= 1'b0;
      bus.hcount_out     <= '0;
      bus.vcount_out     <= '0;
      bus.pixel_out      <= '0;
    end else begin
      bus.data_valid_out <= sb_vld;
      bus.hcount_out     <= sb_h;
      bus.vcount_out     <= sb_v;
      bus.pixel_out      <= (sb_vld && sb_rng) ? bus.rdata_in : '0;
    end
  end

endmodule
